// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers one payload from the upstream source, then streams
// header, payload and parity bytes to the router, honouring the router's busy stall.
module router_pkt_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] din,
  output logic       pkt_valid,
  output logic       tx_busy,
  output logic       done,
  output logic       err
);

  // state   | meaning
  // IDLE    | waiting for start; rejects bad length/address with err
  // LOAD    | pl_ready high, capturing payload bytes into the buffer
  // HEADER  | presenting {len, addr} to the router
  // PAYLOAD | presenting buffered bytes in load order
  // PARITY  | presenting XOR of header and payload, pkt_valid low
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] HEADER  = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] PARITY  = 3'd4;

  logic [2:0] state;
  logic [5:0] len_q;
  logic [1:0] addr_q;
  logic [5:0] idx;
  logic [5:0] bytes_left;
  logic [7:0] parity;
  logic       done_q;
  logic       err_q;
  logic [7:0] buffer [0:62];

  logic [7:0] header;
  logic       start_ok;

  assign header   = {len_q, addr_q};
  assign start_ok = (payload_len != 6'd0) && (dest_addr != 2'b11);

  // bytes_left counts down to terminal count 0 on the last byte of LOAD and PAYLOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= 6'd0;
      addr_q     <= 2'd0;
      idx        <= 6'd0;
      bytes_left <= 6'd0;
      parity     <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              len_q      <= payload_len;
              addr_q     <= dest_addr;
              idx        <= 6'd0;
              bytes_left <= payload_len - 6'd1;
              parity     <= 8'd0;
              state      <= LOAD;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (pl_valid) begin
            parity <= parity ^ pl_data;
            if (bytes_left == 6'd0) begin
              idx        <= 6'd0;
              bytes_left <= len_q - 6'd1;
              state      <= HEADER;
            end else begin
              idx        <= idx + 6'd1;
              bytes_left <= bytes_left - 6'd1;
            end
          end
        end
        HEADER: begin
          if (!busy) begin
            parity <= parity ^ header;
            state  <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            if (bytes_left == 6'd0) begin
              idx   <= 6'd0;
              state <= PARITY;
            end else begin
              idx        <= idx + 6'd1;
              bytes_left <= bytes_left - 6'd1;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // payload storage needs no reset; it is always written before it is read
  always_ff @(posedge clk) begin
    if (!rst && state == LOAD && pl_valid) begin
      buffer[idx] <= pl_data;
    end
  end

  // Outputs depend only on flops, so busy stalls hold din/pkt_valid naturally
  always_comb begin
    din       = 8'd0;
    pkt_valid = 1'b0;
    case (state)
      HEADER: begin
        din       = header;
        pkt_valid = 1'b1;
      end
      PAYLOAD: begin
        din       = buffer[idx];
        pkt_valid = 1'b1;
      end
      PARITY: begin
        din       = parity;
        pkt_valid = 1'b0;
      end
      default: begin
        din       = 8'd0;
        pkt_valid = 1'b0;
      end
    endcase
  end

  assign pl_ready = (state == LOAD);
  assign tx_busy  = (state != IDLE);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: packets are expanded into expected router
// byte streams by a reference model; a negedge monitor compares what the DUT emits.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [7:0] din;
  logic       pkt_valid;
  logic       tx_busy;
  logic       done;
  logic       err;

  router_pkt_tx dut (
    .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr),
    .payload_len(payload_len), .pl_data(pl_data), .pl_valid(pl_valid),
    .pl_ready(pl_ready), .busy(busy), .din(din), .pkt_valid(pkt_valid),
    .tx_busy(tx_busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q [$];
  logic [7:0] pl_bytes [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // A byte is on offer to the router whenever the block is transmitting (not idle, not loading)
  always @(negedge clk) begin
    if (!rst && tx_busy && !pl_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_byte", {23'd0, pkt_valid, din}, 32'h1ff);
      end else begin
        chk("sb_byte", {23'd0, pkt_valid, din}, {23'd0, exp_q[0]});
        if (!busy) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_idle(input string tag);
    chk({tag, "_pkt_valid"}, pkt_valid, 0);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_tx_busy"}, tx_busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_pl_ready"}, pl_ready, 0);
  endtask

  // busy_mode: 0 never busy, 1 random busy, 2 busy for cycles 3..5 after LOAD exit
  task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len,
                          input int busy_mode, input int abort_at);
    int k, nstall, guard, i;
    logic [7:0] par;
    guard = 0;
    while (tx_busy && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    start = 1'b1; dest_addr = addr; payload_len = len;
    par = {len, addr};
    exp_q.push_back({1'b1, len, addr});
    for (int j = 0; j < int'(len); j++) begin
      exp_q.push_back({1'b1, pl_bytes[j]});
      par ^= pl_bytes[j];
    end
    exp_q.push_back({1'b0, par});
    @(posedge clk); #1;
    start = 1'b0; dest_addr = 2'($urandom); payload_len = 6'($urandom);
    @(negedge clk);
    chk("load_pl_ready", pl_ready, 1);
    chk("load_tx_busy", tx_busy, 1);
    i = 0; guard = 0;
    while (i < int'(len) && guard < 400) begin
      pl_valid = ($urandom_range(0, 3) != 0);
      pl_data  = pl_valid ? pl_bytes[i] : 8'($urandom);
      @(posedge clk); #1;
      if (pl_valid) i++;
      guard++;
    end
    pl_valid = ($urandom_range(0, 1) == 1);
    pl_data  = 8'($urandom);
    chk("load_count", i, len);
    chk("load_exit", pl_ready, 0);
    k = 0; nstall = 0;
    for (guard = 0; guard < 1000; guard++) begin
      if (abort_at >= 0 && k == abort_at) begin
        busy = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; pl_valid = 1'b0;
        @(negedge clk);
        check_idle("abort");
        exp_q.delete();
        return;
      end
      case (busy_mode)
        1:       busy = ($urandom_range(0, 2) == 0);
        2:       busy = (k >= 3 && k <= 5);
        default: busy = 1'b0;
      endcase
      if (busy && tx_busy) nstall++;
      start = tx_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      dest_addr = 2'($urandom); payload_len = 6'($urandom);
      @(negedge clk);
      if (done) break;
      k++;
      @(posedge clk); #1;
    end
    chk("done_seen", done, 1);
    chk("xfer_cycles", k, int'(len) + 2 + nstall);
    chk("sb_drained", exp_q.size(), 0);
    start = 1'b0; busy = 1'b0; pl_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic reject(input logic [1:0] addr, input logic [5:0] len);
    start = 1'b1; dest_addr = addr; payload_len = len;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("reject_err", err, 1);
    chk("reject_tx_busy", tx_busy, 0);
    chk("reject_pkt_valid", pkt_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reject_err_pulse", err, 0);
    chk("reject_stay_idle", tx_busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dest_addr = 2'd0; payload_len = 6'd0;
    pl_data = 8'd0; pl_valid = 1'b0; busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    pl_bytes[0] = 8'h11; pl_bytes[1] = 8'h22;
    send_pkt(2'd0, 6'd2, 0, -1);

    for (int j = 0; j < 64; j++) pl_bytes[j] = 8'($urandom);
    send_pkt(2'd1, 6'd4, 2, -1);

    reject(2'd3, 6'd5);
    reject(2'd1, 6'd0);

    for (int j = 0; j < 64; j++) pl_bytes[j] = 8'($urandom);
    send_pkt(2'd0, 6'd8, 0, 4);
    pl_bytes[0] = 8'hFF;
    send_pkt(2'd2, 6'd1, 0, -1);

    for (int j = 0; j < 64; j++) pl_bytes[j] = 8'($urandom);
    send_pkt(2'd2, 6'd63, 0, -1);

    for (int n = 0; n < 20; n++) begin
      for (int j = 0; j < 64; j++) pl_bytes[j] = 8'($urandom);
      send_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, 63)),
               int'($urandom_range(0, 2)), -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
